// File: rtl/mult_pack_sched.sv
// mult_pack_sched: packs 4x2 half ops in pairs for a fracturable
// 8x4 multiplier; two-stage pipe (operand regs -> result regs).
// Ports: clk, rst_n (async, active-low)
//   in_*  : request (valid/ready, full, a, b, signed, tag)
//   mul_* : registered operands/modes to multiplier, mul_c product back
//   out_* : result (valid/ready, full, p, lane valids, lane tags)
module mult_pack_sched #(
    parameter int TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_full,
    input  logic [7:0]  in_a,
    input  logic [3:0]  in_b,
    input  logic        in_signed,
    input  logic [3:0]  in_tag,
    output logic [7:0]  mul_a,
    output logic [3:0]  mul_b,
    output logic        mul_a_sign,
    output logic        mul_b_sign,
    output logic        mul_half0,
    output logic        mul_half1,
    input  logic [11:0] mul_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_full,
    output logic [11:0] out_p,
    output logic        out_lo_vld,
    output logic        out_hi_vld,
    output logic [3:0]  out_tag_lo,
    output logic [3:0]  out_tag_hi
);

    typedef enum logic {EMPTY, PEND} state_t;

    state_t      state, state_nx;
    logic [3:0]  pa, ptag, cnt, cnt_nx;
    logic [1:0]  pb;
    logic        psign;

    logic        s1_valid, s1_lo_vld, s1_hi_vld;
    logic [3:0]  s1_tag_lo, s1_tag_hi;

    logic        adv, s1_ok, incompat, acc;
    logic        ld_full, ld_pair, ld_lone, buf_ld, ld_any;

    logic [7:0]  a_nx;
    logic [3:0]  b_nx, tl_nx, th_nx;
    logic        sg_nx, h1_nx, hv_nx;

    assign mul_half0  = 1'b0;
    assign mul_b_sign = mul_a_sign;

    assign adv      = !out_valid || out_ready;
    assign s1_ok    = !s1_valid || adv;
    assign incompat = in_full || (in_signed != psign);
    assign acc      = in_valid && in_ready;
    assign ld_any   = ld_full || ld_pair || ld_lone;

    // Packer: next state, handshake and S1 load selects
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        in_ready = 1'b0;
        ld_full  = 1'b0;
        ld_pair  = 1'b0;
        ld_lone  = 1'b0;
        buf_ld   = 1'b0;
        unique case (state)
            EMPTY: begin
                // a half op only goes to the buffer, so S1 need not be free
                in_ready = in_full ? s1_ok : 1'b1;
                if (in_valid && in_ready) begin
                    if (in_full) begin
                        ld_full = 1'b1;
                    end else begin
                        buf_ld   = 1'b1;
                        cnt_nx   = 4'd0;
                        state_nx = PEND;
                    end
                end
            end
            PEND: begin
                if (in_valid && !incompat) begin
                    in_ready = s1_ok;
                    if (s1_ok) begin
                        ld_pair  = 1'b1;
                        state_nx = EMPTY;
                    end
                end else if ((in_valid || cnt == 4'(TIMEOUT)) && s1_ok) begin
                    // flush the buffered op alone; the blocked request
                    // is taken on a later cycle
                    ld_lone  = 1'b1;
                    state_nx = EMPTY;
                end
                if (!ld_pair && !ld_lone && cnt != 4'(TIMEOUT))
                    cnt_nx = cnt + 4'd1;
            end
            default: state_nx = EMPTY;
        endcase
    end

    // S1 operand/mode selection
    always_comb begin
        a_nx  = 8'd0;
        b_nx  = 4'd0;
        sg_nx = 1'b0;
        h1_nx = 1'b0;
        hv_nx = 1'b0;
        tl_nx = 4'd0;
        th_nx = 4'd0;
        unique case (1'b1)
            ld_full: begin
                a_nx  = in_a;
                b_nx  = in_b;
                sg_nx = in_signed;
                tl_nx = in_tag;
            end
            ld_pair: begin
                a_nx  = {in_a[3:0], pa};
                b_nx  = {in_b[1:0], pb};
                sg_nx = psign;
                h1_nx = 1'b1;
                hv_nx = 1'b1;
                tl_nx = ptag;
                th_nx = in_tag;
            end
            ld_lone: begin
                a_nx  = {4'd0, pa};
                b_nx  = {2'd0, pb};
                sg_nx = psign;
                h1_nx = 1'b1;
                tl_nx = ptag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            cnt   <= 4'd0;
            pa    <= 4'd0;
            pb    <= 2'd0;
            psign <= 1'b0;
            ptag  <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (buf_ld && acc) begin
                pa    <= in_a[3:0];
                pb    <= in_b[1:0];
                psign <= in_signed;
                ptag  <= in_tag;
            end
        end
    end

    // S1: operand registers feeding the multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            mul_a      <= 8'd0;
            mul_b      <= 4'd0;
            mul_a_sign <= 1'b0;
            mul_half1  <= 1'b0;
            s1_lo_vld  <= 1'b0;
            s1_hi_vld  <= 1'b0;
            s1_tag_lo  <= 4'd0;
            s1_tag_hi  <= 4'd0;
        end else if (s1_ok) begin
            s1_valid <= ld_any;
            if (ld_any) begin
                mul_a      <= a_nx;
                mul_b      <= b_nx;
                mul_a_sign <= sg_nx;
                mul_half1  <= h1_nx;
                s1_lo_vld  <= 1'b1;
                s1_hi_vld  <= hv_nx;
                s1_tag_lo  <= tl_nx;
                s1_tag_hi  <= th_nx;
            end
        end
    end

    // S2: result register, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_full   <= 1'b0;
            out_p      <= 12'd0;
            out_lo_vld <= 1'b0;
            out_hi_vld <= 1'b0;
            out_tag_lo <= 4'd0;
            out_tag_hi <= 4'd0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_full   <= !mul_half1;
                out_p      <= mul_c;
                out_lo_vld <= s1_lo_vld;
                out_hi_vld <= s1_hi_vld;
                out_tag_lo <= s1_tag_lo;
                out_tag_hi <= s1_tag_hi;
            end
        end
    end

endmodule
